cpu_clock_sequencer: RTL and testbench



---
 rtl/cpu_clk_pkg.sv | 14 +
 rtl/cpu_clock_sequencer_debouncer.sv | 49 ++++
 rtl/cpu_clock_sequencer.sv | 110 +++++++++++
 tb/tb_cpu_clock_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared state encoding and default timing constants for the CPU clock sequencer.
package cpu_clk_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STEP    = 2'd1,
      WAIT_IN = 2'd2,
      HALTED  = 2'd3
   } state_t;

   localparam int unsigned DEF_DIV_COUNT      = 3000000;
   localparam int unsigned DEF_DEBOUNCE_COUNT = 50000;

endpackage

// File: rtl/cpu_clock_sequencer_debouncer.sv
// Push-button synchronizer and debouncer; emits a one-cycle pulse on an accepted press.
module button_debouncer
   import cpu_clk_pkg::*;
#(
   parameter int unsigned DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic press_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_COUNT - 1);

   logic          sync1;
   logic          sync2;
   logic          prev;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         prev   <= 1'b1;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         prev  <= stable;
         // The new level is accepted on the edge the counter would reach DEBOUNCE_COUNT.
         if (sync2 != stable) begin
            if (cnt == LAST) begin
               stable <= sync2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press_pulse = prev & ~stable;

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Clock-enable scheduler for the unicycle MIPS core: free-run divider, manual step,
// input-wait stall and sticky halt, plus visible clock, status LED and cycle counter.
module cpu_clock_sequencer
   import cpu_clk_pkg::*;
#(
   parameter int unsigned DIV_COUNT      = DEF_DIV_COUNT,
   parameter int unsigned DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
   parameter int unsigned CYC_W          = 32
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic             switch_hold,
   input  logic             push_manual_clock,
   input  logic             flag_input,
   input  logic             input_confirm,
   input  logic             halt,
   output logic             cpu_clk_en,
   output logic             clock,
   output logic             clock_status,
   output logic [1:0]       state,
   output logic [CYC_W-1:0] cycle_count
);

   localparam int unsigned DW = $clog2(DIV_COUNT);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

   state_t        cur;
   state_t        nxt;
   logic [DW-1:0] div;
   logic [DW-1:0] div_n;
   logic          clock_n;
   logic          en_n;
   logic          btn_stable;
   logic          press_pulse;
   logic          step_press;

   button_debouncer #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_debouncer (
      .clk_50     (clk_50),
      .rst_n      (rst_n),
      .raw        (push_manual_clock),
      .stable     (btn_stable),
      .press_pulse(press_pulse)
   );

   assign step_press = press_pulse & ~btn_stable;

   always_comb begin
      if (cur == HALTED || halt)
         nxt = HALTED;
      else if (flag_input && !input_confirm)
         nxt = WAIT_IN;
      else if (switch_hold)
         nxt = STEP;
      else
         nxt = RUN;
   end

   // Decisions use the next state, so a stall or halt arriving with a due strobe wins.
   always_comb begin
      div_n   = div;
      clock_n = clock;
      en_n    = 1'b0;
      case (nxt)
         STEP: begin
            div_n   = '0;
            clock_n = (cur == STEP) && step_press;
            en_n    = (cur == STEP) && step_press;
         end
         RUN: begin
            if (cur == STEP) begin
               div_n   = '0;
               clock_n = 1'b0;
            end else if (div == DIV_LAST) begin
               div_n   = '0;
               clock_n = ~clock;
               en_n    = ~clock;
            end else begin
               div_n = div + DW'(1);
            end
         end
         default: begin
            div_n   = div;
            clock_n = clock;
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         cur         <= RUN;
         div         <= '0;
         clock       <= 1'b0;
         cpu_clk_en  <= 1'b0;
         cycle_count <= '0;
      end else begin
         cur        <= nxt;
         div        <= div_n;
         clock      <= clock_n;
         cpu_clk_en <= en_n;
         if (cpu_clk_en && (cycle_count != '1))
            cycle_count <= cycle_count + CYC_W'(1);
      end
   end

   assign clock_status = (cur == WAIT_IN || cur == HALTED) ? 1'b1 : clock;
   assign state        = cur;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe edges/counts, a monitor checks each strobe.
module tb_cpu_clock_sequencer;

   localparam int DIV = 5;
   localparam int DEB = 4;
   localparam int CW  = 4;

   logic          clk_50 = 1'b0;
   logic          rst_n = 1'b0;
   logic          switch_hold = 1'b0;
   logic          push_manual_clock = 1'b1;
   logic          flag_input = 1'b0;
   logic          input_confirm = 1'b0;
   logic          halt = 1'b0;
   logic          cpu_clk_en;
   logic          clock;
   logic          clock_status;
   logic [1:0]    state;
   logic [CW-1:0] cycle_count;

   cpu_clock_sequencer #(
      .DIV_COUNT     (DIV),
      .DEBOUNCE_COUNT(DEB),
      .CYC_W         (CW)
   ) dut (
      .clk_50           (clk_50),
      .rst_n            (rst_n),
      .switch_hold      (switch_hold),
      .push_manual_clock(push_manual_clock),
      .flag_input       (flag_input),
      .input_confirm    (input_confirm),
      .halt             (halt),
      .cpu_clk_en       (cpu_clk_en),
      .clock            (clock),
      .clock_status     (clock_status),
      .state            (state),
      .cycle_count      (cycle_count)
   );

   always #10 clk_50 = ~clk_50;

   int edge_no = 0;
   always @(posedge clk_50) edge_no <= edge_no + 1;

   typedef struct {
      int at;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_no);
      end
   endtask

   task automatic expect_strobe(input int at, input int cnt);
      exp_t e;
      e.at  = at;
      e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   always @(negedge clk_50) begin
      if (cpu_clk_en) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe: got strobe at edge %0d expected none", edge_no);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("strobe_edge", edge_no, e.at);
            chk("strobe_count", int'(cycle_count), e.cnt);
            chk("strobe_clock", int'(clock), 1);
         end
      end
   end

   int e0, f0, g0, h0, p0, s0;

   initial begin
      tick(3);
      chk("rst_state", int'(state), 0);
      chk("rst_en", int'(cpu_clk_en), 0);
      chk("rst_clock", int'(clock), 0);
      chk("rst_status", int'(clock_status), 0);
      chk("rst_count", int'(cycle_count), 0);

      // Free run: strobes every 10 edges, first 5 edges after release
      rst_n = 1'b1;
      e0 = edge_no;
      for (int i = 0; i < 4; i++) expect_strobe(e0 + 5 + 10 * i, i);
      tick(7);
      chk("run_clock_hi", int'(clock), 1);
      chk("run_status_hi", int'(clock_status), 1);
      tick(5);
      chk("run_clock_lo", int'(clock), 0);
      chk("run_status_lo", int'(clock_status), 0);
      tick(28);
      chk("run_count4", int'(cycle_count), 4);

      // Manual step: held press gives one strobe 6 edges after first low sample
      f0 = edge_no;
      switch_hold = 1'b1;
      tick(1);
      push_manual_clock = 1'b0;
      expect_strobe(f0 + 8, 4);
      tick(8);
      chk("step_clock_after", int'(clock), 0);
      chk("step_state", int'(state), 1);
      tick(12);
      push_manual_clock = 1'b1;
      tick(10);
      chk("step_count5", int'(cycle_count), 5);
      push_manual_clock = 1'b0;
      tick(3);
      push_manual_clock = 1'b1;
      tick(10);
      chk("glitch_count", int'(cycle_count), 5);

      // Input wait: divider frozen at 2, resumes to strobe 3 edges after confirm
      g0 = edge_no;
      switch_hold = 1'b0;
      tick(3);
      flag_input = 1'b1;
      tick(12);
      chk("wait_state", int'(state), 2);
      chk("wait_status", int'(clock_status), 1);
      chk("wait_clock", int'(clock), 0);
      chk("wait_count", int'(cycle_count), 5);
      input_confirm = 1'b1;
      expect_strobe(g0 + 18, 5);
      tick(1);
      flag_input = 1'b0;
      input_confirm = 1'b0;
      tick(5);
      chk("resume_count", int'(cycle_count), 6);

      // Halt pulse exactly on the edge a strobe is due
      tick(6);
      halt = 1'b1;
      tick(1);
      halt = 1'b0;
      chk("halt_state", int'(state), 3);
      switch_hold = 1'b1;
      push_manual_clock = 1'b0;
      tick(10);
      push_manual_clock = 1'b1;
      tick(10);
      switch_hold = 1'b0;
      tick(10);
      chk("halt_sticky", int'(state), 3);
      chk("halt_status", int'(clock_status), 1);
      chk("halt_clock", int'(clock), 0);
      chk("halt_count", int'(cycle_count), 6);

      rst_n = 1'b0;
      tick(1);
      chk("rst2_state", int'(state), 0);
      chk("rst2_count", int'(cycle_count), 0);
      chk("rst2_clock", int'(clock), 0);

      // Saturation: 20 strobes, counter sticks at 15
      rst_n = 1'b1;
      h0 = edge_no;
      for (int i = 0; i < 20; i++) expect_strobe(h0 + 5 + 10 * i, (i > 15) ? 15 : i);
      tick(200);
      chk("sat_count", int'(cycle_count), 15);

      // Press accepted during RUN is discarded when switching to STEP
      p0 = edge_no;
      push_manual_clock = 1'b0;
      expect_strobe(p0 + 5, 15);
      tick(6);
      switch_hold = 1'b1;
      tick(10);
      chk("stale_state", int'(state), 1);
      chk("stale_clock", int'(clock), 0);
      push_manual_clock = 1'b1;
      tick(10);

      // STEP -> RUN while the step strobe is live
      s0 = edge_no;
      push_manual_clock = 1'b0;
      expect_strobe(s0 + 7, 15);
      expect_strobe(s0 + 13, 15);
      tick(7);
      switch_hold = 1'b0;
      tick(1);
      chk("mode_clock", int'(clock), 0);
      chk("mode_state", int'(state), 0);
      tick(6);
      push_manual_clock = 1'b1;
      tick(3);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
